// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array tile: scheduler state encoding
// and the default array dimension used by the PE array and its scheduler.
package sa_pkg;

  localparam int SA_N = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } sa_state_e;

  // Phase counter must hold the largest vector count and the drain length.
  function automatic int sa_cnt_width(input int n, input int len_w);
    int skew_w;
    skew_w = $clog2(2 * n);
    return (len_w > skew_w) ? len_w : skew_w;
  endfunction

endpackage

// File: rtl/sa_tile_sched.sv
// Tile scheduler for an N x N systolic array: loads N weight rows, streams
// vec_len activation vectors, drains the 2N-1 cycle skew, then pulses done.
module sa_tile_sched
  import sa_pkg::*;
#(
  parameter int N     = SA_N,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     vec_len,
  input  logic                 w_ready,
  input  logic                 a_ready,
  output logic                 w_ps,
  output logic                 w_valid,
  output logic [$clog2(N)-1:0] w_row,
  output logic                 a_en,
  output logic                 drain,
  output logic                 busy,
  output logic                 done
);

  localparam int RW = $clog2(N);
  localparam int CW = sa_cnt_width(N, LEN_W);

  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] LAST_ROW   = CW'(N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 2);

  sa_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              w_ps_q, w_ps_d;
  logic              w_valid_q, w_valid_d;
  logic [RW-1:0]     w_row_q, w_row_d;
  logic              drain_q, drain_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CW-1:0]     cnt_inc;
  logic [CW-1:0]     len_ext;

  // a_en must follow a_ready within the same cycle, so it is gated from
  // the registered state rather than registered itself.
  assign a_en    = (state_q == S_COMPUTE) && a_ready;
  assign cnt_inc = cnt_q + ONE;
  assign len_ext = CW'(len_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    w_ps_d    = w_ps_q;
    w_valid_d = w_valid_q;
    w_row_d   = w_row_q;
    drain_d   = drain_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD_W;
          len_d     = vec_len;
          cnt_d     = '0;
          w_ps_d    = 1'b1;
          w_valid_d = 1'b1;
          w_row_d   = '0;
          busy_d    = 1'b1;
        end
      end

      S_LOAD_W: begin
        if (w_ready) begin
          if (cnt_q == LAST_ROW) begin
            cnt_d     = '0;
            w_ps_d    = 1'b0;
            w_valid_d = 1'b0;
            w_row_d   = '0;
            if (len_q != '0) begin
              state_d = S_COMPUTE;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d   = cnt_inc;
            w_row_d = cnt_inc[RW-1:0];
          end
        end
      end

      S_COMPUTE: begin
        if (a_en) begin
          if (cnt_inc == len_ext) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
            drain_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          drain_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        w_ps_d    = 1'b0;
        w_valid_d = 1'b0;
        w_row_d   = '0;
        drain_d   = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      w_ps_q    <= 1'b0;
      w_valid_q <= 1'b0;
      w_row_q   <= '0;
      drain_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      w_ps_q    <= w_ps_d;
      w_valid_q <= w_valid_d;
      w_row_q   <= w_row_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign w_ps    = w_ps_q;
  assign w_valid = w_valid_q;
  assign w_row   = w_row_q;
  assign drain   = drain_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
